// File: rtl/pedestrian_crossing_ctrl.sv
// Multi-crossing pedestrian signal controller with its own 1 s time base.
// Per crossing: request latch, grant-gated WALK, flashing CLEAR countdown, 7-seg digits.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   enable                global run; low parks every channel in IDLE
//   request[N], grant[N]  button input and master grant per crossing
//   walk_light[N]         steady WALK lamp
//   hand_light[N]         DON'T-WALK lamp (flashes during CLEAR)
//   pending[N]            request latched, not yet served
//   done[N]               one-cycle pulse when a crossing finishes CLEAR
//   tens_digit/ones_digit 7 bits per channel at [7i+6:7i], gfedcba, bit0 = a
module pedestrian_crossing_ctrl #(
  parameter int NUM_CROSSINGS = 2,
  parameter int TICKS_PER_SEC = 50,
  parameter int WALK_TIME     = 7,
  parameter int CLEAR_TIME    = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CROSSINGS-1:0]   request,
  input  logic [NUM_CROSSINGS-1:0]   grant,
  output logic [NUM_CROSSINGS-1:0]   walk_light,
  output logic [NUM_CROSSINGS-1:0]   hand_light,
  output logic [NUM_CROSSINGS-1:0]   pending,
  output logic [NUM_CROSSINGS-1:0]   done,
  output logic [7*NUM_CROSSINGS-1:0] tens_digit,
  output logic [7*NUM_CROSSINGS-1:0] ones_digit
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICKS_PER_SEC / 2);

  localparam logic [6:0] WALK_CNT  = 7'(WALK_TIME);
  localparam logic [6:0] CLEAR_CNT = 7'(CLEAR_TIME);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WALK  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [PW-1:0] presc;
  logic          tick;
  logic          flash_on;

  logic [NUM_CROSSINGS-1:0][2:0] state;
  logic [NUM_CROSSINGS-1:0][2:0] state_d;
  logic [NUM_CROSSINGS-1:0][6:0] count;
  logic [NUM_CROSSINGS-1:0][6:0] count_d;
  logic [NUM_CROSSINGS-1:0]      pend_d;

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    case (d)
      4'd0: s = 7'h3F;
      4'd1: s = 7'h06;
      4'd2: s = 7'h5B;
      4'd3: s = 7'h4F;
      4'd4: s = 7'h66;
      4'd5: s = 7'h6D;
      4'd6: s = 7'h7D;
      4'd7: s = 7'h07;
      4'd8: s = 7'h7F;
      4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Free-running time base shared by every channel; never restarted
  // on state entry, so the first second of a phase may be short.
  assign tick     = (presc == P_LAST);
  assign flash_on = (presc < P_HALF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    pend_d  = pending;
    for (int i = 0; i < NUM_CROSSINGS; i++) begin
      unique case (state[i])
        S_IDLE: begin
          if (request[i]) begin
            pend_d[i]  = 1'b1;
            state_d[i] = S_WAIT;
          end
        end
        S_WAIT: begin
          if (grant[i]) begin
            pend_d[i]  = 1'b0;
            state_d[i] = S_WALK;
            count_d[i] = WALK_CNT;
          end
        end
        S_WALK: begin
          // Losing the grant cuts WALK short straight into CLEAR.
          if (!grant[i]) begin
            state_d[i] = S_CLEAR;
            count_d[i] = CLEAR_CNT;
          end else if (tick) begin
            if (count[i] == 7'd1) begin
              state_d[i] = S_CLEAR;
              count_d[i] = CLEAR_CNT;
            end else begin
              count_d[i] = count[i] - 7'd1;
            end
          end
        end
        S_CLEAR: begin
          if (request[i]) begin
            pend_d[i] = 1'b1;
          end
          if (tick) begin
            if (count[i] == 7'd1) begin
              state_d[i] = S_DONE;
            end else begin
              count_d[i] = count[i] - 7'd1;
            end
          end
        end
        S_DONE: begin
          if (pending[i] || request[i]) begin
            pend_d[i]  = 1'b1;
            state_d[i] = S_WAIT;
          end else begin
            state_d[i] = S_IDLE;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          pend_d[i]  = 1'b0;
        end
      endcase
      if (!enable) begin
        state_d[i] = S_IDLE;
        count_d[i] = 7'd0;
        pend_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      pending <= pend_d;
    end
  end

  // Lamps and digits follow the current state one cycle later;
  // a low enable blanks them at once so no stale CLEAR or done shows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      walk_light <= '0;
      hand_light <= '1;
      done       <= '0;
      tens_digit <= '0;
      ones_digit <= '0;
    end else begin
      for (int i = 0; i < NUM_CROSSINGS; i++) begin
        if (!enable) begin
          walk_light[i]     <= 1'b0;
          hand_light[i]     <= 1'b1;
          done[i]           <= 1'b0;
          tens_digit[7*i+:7] <= 7'h00;
          ones_digit[7*i+:7] <= 7'h00;
        end else begin
          walk_light[i] <= (state[i] == S_WALK);
          done[i]       <= (state[i] == S_DONE);
          unique case (state[i])
            S_WALK:  hand_light[i] <= 1'b0;
            S_CLEAR: hand_light[i] <= flash_on;
            default: hand_light[i] <= 1'b1;
          endcase
          if (state[i] == S_CLEAR) begin
            tens_digit[7*i+:7] <= (count[i] >= 7'd10)
                                ? seg(4'(count[i] / 7'd10))
                                : 7'h00;
            ones_digit[7*i+:7] <= seg(4'(count[i] % 7'd10));
          end else begin
            tens_digit[7*i+:7] <= 7'h00;
            ones_digit[7*i+:7] <= 7'h00;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pedestrian_crossing_ctrl.sv
// Directed bench for pedestrian_crossing_ctrl (N=2, 4 clk/s, WALK 3 s, CLEAR 12 s).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_pedestrian_crossing_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  request;
  logic [1:0]  grant;
  logic [1:0]  walk_light;
  logic [1:0]  hand_light;
  logic [1:0]  pending;
  logic [1:0]  done;
  logic [13:0] tens_digit;
  logic [13:0] ones_digit;

  int compared   = 0;
  int mismatched = 0;

  pedestrian_crossing_ctrl #(
    .NUM_CROSSINGS(2),
    .TICKS_PER_SEC(4),
    .WALK_TIME(3),
    .CLEAR_TIME(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .request(request),
    .grant(grant),
    .walk_light(walk_light),
    .hand_light(hand_light),
    .pending(pending),
    .done(done),
    .tens_digit(tens_digit),
    .ones_digit(ones_digit)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_walk"}, 16'(walk_light), 16'h0);
    chk({tag, "_hand"}, 16'(hand_light), 16'h3);
    chk({tag, "_pend"}, 16'(pending), 16'h0);
    chk({tag, "_done"}, 16'(done), 16'h0);
    chk({tag, "_tens"}, 16'(tens_digit), 16'h0);
    chk({tag, "_ones"}, 16'(ones_digit), 16'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    request = 2'b00;
    grant   = 2'b00;
    step(3);
    chk_idle("rst");
    rst_n = 1'b1;

    // Edge count below is measured from reset release; ticks land on multiples of 4.
    step(20);
    chk_idle("idle20");

    // Channel 0: full cycle with grant held.
    request[0] = 1'b1;
    grant[0]   = 1'b1;
    step(1);
    request[0] = 1'b0;
    chk("c0_pend_set", 16'(pending[0]), 16'h1);
    chk("c0_wait_walk", 16'(walk_light[0]), 16'h0);
    step(1);
    chk("c0_pend_clr", 16'(pending[0]), 16'h0);
    step(1);
    chk("c0_walk_on", 16'(walk_light[0]), 16'h1);
    chk("c0_walk_hand", 16'(hand_light[0]), 16'h0);
    step(9);
    chk("c0_walk_end", 16'(walk_light[0]), 16'h1);
    step(1);
    chk("c0_clr_walk", 16'(walk_light[0]), 16'h0);
    chk("c0_hand_33", 16'(hand_light[0]), 16'h1);
    chk("c0_tens_12", 16'(tens_digit[6:0]), 16'h06);
    chk("c0_ones_12", 16'(ones_digit[6:0]), 16'h5B);
    step(1);
    chk("c0_hand_34", 16'(hand_light[0]), 16'h1);
    step(1);
    chk("c0_hand_35", 16'(hand_light[0]), 16'h0);
    step(1);
    chk("c0_hand_36", 16'(hand_light[0]), 16'h0);
    chk("c0_ones_12b", 16'(ones_digit[6:0]), 16'h5B);
    step(1);
    chk("c0_hand_37", 16'(hand_light[0]), 16'h1);
    chk("c0_tens_11", 16'(tens_digit[6:0]), 16'h06);
    chk("c0_ones_11", 16'(ones_digit[6:0]), 16'h06);
    step(4);
    chk("c0_tens_10", 16'(tens_digit[6:0]), 16'h06);
    chk("c0_ones_10", 16'(ones_digit[6:0]), 16'h3F);
    step(4);
    chk("c0_tens_9", 16'(tens_digit[6:0]), 16'h00);
    chk("c0_ones_9", 16'(ones_digit[6:0]), 16'h6F);
    chk("c1_hand", 16'(hand_light[1]), 16'h1);
    chk("c1_walk", 16'(walk_light[1]), 16'h0);
    chk("c1_tens", 16'(tens_digit[13:7]), 16'h00);
    chk("c1_pend", 16'(pending[1]), 16'h0);
    step(35);
    chk("c0_tens_1", 16'(tens_digit[6:0]), 16'h00);
    chk("c0_ones_1", 16'(ones_digit[6:0]), 16'h06);
    chk("c0_done_pre", 16'(done), 16'h0);
    step(1);
    chk("c0_done", 16'(done), 16'h1);
    chk("c0_done_ones", 16'(ones_digit[6:0]), 16'h00);
    chk("c0_done_hand", 16'(hand_light[0]), 16'h1);
    step(1);
    chk("c0_done_end", 16'(done), 16'h0);
    chk("c0_idle_walk", 16'(walk_light[0]), 16'h0);
    grant[0] = 1'b0;

    // Channel 0: grant withdrawn during WALK.
    request[0] = 1'b1;
    step(1);
    request[0] = 1'b0;
    grant[0]   = 1'b1;
    step(2);
    chk("ab_walk_on", 16'(walk_light[0]), 16'h1);
    grant[0] = 1'b0;
    step(2);
    chk("ab_walk_off", 16'(walk_light[0]), 16'h0);
    chk("ab_tens_12", 16'(tens_digit[6:0]), 16'h06);
    chk("ab_ones_12", 16'(ones_digit[6:0]), 16'h5B);

    // Channel 1: request held into WALK, re-request during CLEAR.
    request[1] = 1'b1;
    grant[1]   = 1'b1;
    step(1);
    chk("c1_pend_set", 16'(pending[1]), 16'h1);
    step(2);
    chk("c1_walk_req_ign", 16'(pending[1]), 16'h0);
    chk("c1_walk_on", 16'(walk_light[1]), 16'h1);
    request[1] = 1'b0;
    step(11);
    grant[1] = 1'b0;
    step(9);
    request[1] = 1'b1;
    step(1);
    request[1] = 1'b0;
    chk("c1_clr_req", 16'(pending[1]), 16'h1);
    step(22);
    chk("ab_done", 16'(done), 16'h1);
    step(1);
    chk("ab_done_end", 16'(done), 16'h0);
    step(15);
    chk("c1_done", 16'(done), 16'h2);
    chk("c1_done_pend", 16'(pending[1]), 16'h1);
    step(1);
    chk("c1_done_end", 16'(done), 16'h0);
    chk("c1_wait_pend", 16'(pending[1]), 16'h1);
    step(1);
    chk("c1_wait_walk", 16'(walk_light[1]), 16'h0);
    chk("c1_wait_pend2", 16'(pending[1]), 16'h1);

    // Both channels into CLEAR, then drop enable.
    request[0] = 1'b1;
    grant[1]   = 1'b1;
    step(1);
    request[0] = 1'b0;
    grant[0]   = 1'b1;
    chk("en_pend", 16'(pending), 16'h1);
    step(1);
    grant = 2'b00;
    step(2);
    chk("en_tens", 16'(tens_digit), 16'({7'h06, 7'h06}));
    chk("en_ones", 16'(ones_digit), 16'({7'h5B, 7'h5B}));
    chk("en_walk", 16'(walk_light), 16'h0);
    step(1);
    enable = 1'b0;
    step(1);
    chk_idle("en_off");
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("en_off_done", 16'(done), 16'h0);
    end
    enable = 1'b1;
    step(8);
    chk_idle("en_on");

    // Reset in the middle of WALK.
    request[0] = 1'b1;
    grant[0]   = 1'b1;
    step(1);
    request[0] = 1'b0;
    step(2);
    chk("rw_walk_on", 16'(walk_light[0]), 16'h1);
    step(1);
    rst_n = 1'b0;
    step(1);
    chk_idle("rw_rst");
    rst_n    = 1'b1;
    grant[0] = 1'b0;
    step(1);
    chk_idle("rw_after");
    step(5);
    chk("rw_no_done", 16'(done), 16'h0);
    chk("rw_no_walk", 16'(walk_light), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
